reg_transfer_ctrl: RTL and testbench



---
 rtl/reg_transfer_ctrl_pkg.sv | 28 ++
 rtl/reg_transfer_ctrl.sv | 150 +++++++++++++++
 tb/tb_reg_transfer_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_transfer_ctrl_pkg.sv
// Shared definitions for the register-transfer sequencer: widths, opcodes, FSM states.
package reg_transfer_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_SWAP = 2'b01,
    OP_LDI  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_S = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_D = 3'd3,
    ST_WR_S = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // MOV and SWAP begin by reading the source; LDI and CLR go straight to the write.
  function automatic logic op_reads_first(input op_e op);
    return (op == OP_MOV) || (op == OP_SWAP);
  endfunction

endpackage

// File: rtl/reg_transfer_ctrl.sv
// Master-side sequencer driving the register file's read and write ports
// for MOV / SWAP / LDI / CLR commands, one command per handshake.
module reg_transfer_ctrl
  import reg_transfer_ctrl_pkg::*;
#(
  parameter int DATA_W = reg_transfer_ctrl_pkg::DATA_W,
  parameter int SEL_W  = reg_transfer_ctrl_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [SEL_W-1:0]  cmd_rd,
  input  logic [SEL_W-1:0]  cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              busy,
  output logic              done,
  output logic [SEL_W-1:0]  rf_sel_out,
  output logic              rf_output_enable,
  input  logic [DATA_W-1:0] rf_data_in,
  output logic [SEL_W-1:0]  rf_sel_in,
  output logic              rf_write_enable,
  output logic [DATA_W-1:0] rf_data_out
);

  state_e              r_state;
  op_e                 r_op;
  logic [SEL_W-1:0]    r_rd;
  logic [SEL_W-1:0]    r_rs;
  logic [DATA_W-1:0]   r_tmp0;
  logic [DATA_W-1:0]   r_tmp1;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_oe;
  logic                r_we;
  logic [SEL_W-1:0]    r_sel_out;
  logic [SEL_W-1:0]    r_sel_in;
  logic [DATA_W-1:0]   r_data_out;
  op_e                 w_cmd_op;

  assign w_cmd_op = op_e'(cmd_op);

  // FSM and datapath: every output is registered for the state being entered,
  // so write data for a cycle is computed from the read data captured at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_MOV;
      r_rd       <= '0;
      r_rs       <= '0;
      r_tmp0     <= '0;
      r_tmp1     <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_oe       <= 1'b0;
      r_we       <= 1'b0;
      r_sel_out  <= '0;
      r_sel_in   <= '0;
      r_data_out <= '0;
    end else begin
      // Strobes are single-cycle; data_out returns to zero outside write states.
      r_done     <= 1'b0;
      r_oe       <= 1'b0;
      r_we       <= 1'b0;
      r_data_out <= '0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op    <= w_cmd_op;
            r_rd    <= cmd_rd;
            r_rs    <= cmd_rs;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (op_reads_first(w_cmd_op)) begin
              r_state   <= ST_RD_S;
              r_oe      <= 1'b1;
              r_sel_out <= cmd_rs;
            end else begin
              r_state    <= ST_WR_D;
              r_we       <= 1'b1;
              r_sel_in   <= cmd_rd;
              r_data_out <= (w_cmd_op == OP_LDI) ? cmd_imm : '0;
            end
          end else begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_RD_S: begin
          r_tmp0 <= rf_data_in;
          if (r_op == OP_SWAP) begin
            r_state   <= ST_RD_D;
            r_oe      <= 1'b1;
            r_sel_out <= r_rd;
          end else begin
            r_state    <= ST_WR_D;
            r_we       <= 1'b1;
            r_sel_in   <= r_rd;
            r_data_out <= rf_data_in;
          end
        end
        ST_RD_D: begin
          r_tmp1     <= rf_data_in;
          r_state    <= ST_WR_D;
          r_we       <= 1'b1;
          r_sel_in   <= r_rd;
          r_data_out <= r_tmp0;
        end
        ST_WR_D: begin
          if (r_op == OP_SWAP) begin
            r_state    <= ST_WR_S;
            r_we       <= 1'b1;
            r_sel_in   <= r_rs;
            r_data_out <= r_tmp1;
          end else begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_WR_S: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready        = r_ready;
  assign busy             = r_busy;
  assign done             = r_done;
  assign rf_sel_out       = r_sel_out;
  assign rf_output_enable = r_oe;
  assign rf_sel_in        = r_sel_in;
  assign rf_write_enable  = r_we;
  assign rf_data_out      = r_data_out;

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// Directed bench for reg_transfer_ctrl with a behavioural 8x16 register file.
module tb_reg_transfer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_rs;
  logic [15:0] cmd_imm;
  logic        busy;
  logic        done;
  logic [2:0]  rf_sel_out;
  logic        rf_output_enable;
  logic [15:0] rf_data_in;
  logic [2:0]  rf_sel_in;
  logic        rf_write_enable;
  logic [15:0] rf_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rf [8] = '{default: 16'h0000};
  int          edge_ctr = 0;
  int          acc_edge = 0;
  int          wr_n = 0;
  int          rd_n = 0;
  int          both_n = 0;
  logic [2:0]  wr_sel [64];
  logic [15:0] wr_dat [64];
  int          wr_rel [64];
  logic [2:0]  rd_sel [64];
  int          wr_base;
  int          rd_base;

  reg_transfer_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_rd           (cmd_rd),
    .cmd_rs           (cmd_rs),
    .cmd_imm          (cmd_imm),
    .busy             (busy),
    .done             (done),
    .rf_sel_out       (rf_sel_out),
    .rf_output_enable (rf_output_enable),
    .rf_data_in       (rf_data_in),
    .rf_sel_in        (rf_sel_in),
    .rf_write_enable  (rf_write_enable),
    .rf_data_out      (rf_data_out)
  );

  always #5 clk = ~clk;

  assign rf_data_in = rf_output_enable ? rf[rf_sel_out] : 16'h0000;

  // Register file responder plus a log of every read and write cycle.
  always @(posedge clk) begin
    if (rf_write_enable) begin
      rf[rf_sel_in] <= rf_data_out;
      if (wr_n < 64) begin
        wr_sel[wr_n] = rf_sel_in;
        wr_dat[wr_n] = rf_data_out;
        wr_rel[wr_n] = edge_ctr - acc_edge + 1;
      end
      wr_n = wr_n + 1;
    end
    if (rf_output_enable) begin
      if (rd_n < 64) rd_sel[rd_n] = rf_sel_out;
      rd_n = rd_n + 1;
    end
    if (rf_output_enable && rf_write_enable) both_n = both_n + 1;
    edge_ctr = edge_ctr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and measure cycles from the acceptance edge to done.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [15:0] imm, input int exp_lat, input string tag);
    int cyc;
    @(negedge clk);
    chk({tag, "_ready"}, {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    wr_base = wr_n; rd_base = rd_n;
    @(negedge clk);
    acc_edge = edge_ctr;
    cmd_valid = 1'b0; cmd_op = ~op; cmd_rd = ~rd; cmd_rs = ~rs; cmd_imm = ~imm;
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    cyc = 1;
    while (!done && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, cyc, exp_lat);
    @(negedge clk);
  endtask

  logic [1:0]  q_op  [3];
  logic [2:0]  q_rd  [3];
  logic [2:0]  q_rs  [3];
  logic [15:0] q_imm [3];
  int          acc_at [3];

  initial begin
    int n_acc;
    int viol;
    int done_cnt;
    bit pending;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rd = 3'd0; cmd_rs = 3'd0; cmd_imm = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_oe", {31'b0, rf_output_enable}, 32'd0);
    chk("rst_we", {31'b0, rf_write_enable}, 32'd0);
    chk("rst_sel_out", {29'b0, rf_sel_out}, 32'd0);
    chk("rst_sel_in", {29'b0, rf_sel_in}, 32'd0);
    chk("rst_dout", {16'b0, rf_data_out}, 32'd0);
    rst = 1'b0;

    // LDI R2 = 0x1234
    run_cmd(2'b10, 3'd2, 3'd0, 16'h1234, 2, "ldi_r2");
    chk("ldi_r2_wrn", wr_n - wr_base, 1);
    chk("ldi_r2_wr", {wr_sel[wr_base], wr_dat[wr_base]}, {16'h0, 16'h1234} | 32'h0002_0000);
    chk("ldi_r2_rel", wr_rel[wr_base], 1);
    chk("ldi_r2_rdn", rd_n - rd_base, 0);

    // MOV R5 <- R2
    run_cmd(2'b00, 3'd5, 3'd2, 16'hFFFF, 3, "mov");
    chk("mov_rdn", rd_n - rd_base, 1);
    chk("mov_rdsel", {29'b0, rd_sel[rd_base]}, 32'd2);
    chk("mov_wrn", wr_n - wr_base, 1);
    chk("mov_wrsel", {29'b0, wr_sel[wr_base]}, 32'd5);
    chk("mov_wrdat", {16'b0, wr_dat[wr_base]}, 32'h1234);
    chk("mov_rel", wr_rel[wr_base], 2);
    chk("mov_r5", {16'b0, rf[5]}, 32'h1234);
    chk("mov_r2", {16'b0, rf[2]}, 32'h1234);

    // SWAP R1 <-> R6
    run_cmd(2'b10, 3'd1, 3'd0, 16'hAAAA, 2, "ldi_r1");
    run_cmd(2'b10, 3'd6, 3'd0, 16'h5555, 2, "ldi_r6");
    run_cmd(2'b01, 3'd1, 3'd6, 16'h0000, 5, "swap");
    chk("swap_rdn", rd_n - rd_base, 2);
    chk("swap_rd0", {29'b0, rd_sel[rd_base]}, 32'd6);
    chk("swap_rd1", {29'b0, rd_sel[rd_base+1]}, 32'd1);
    chk("swap_wrn", wr_n - wr_base, 2);
    chk("swap_wr0", {13'b0, wr_sel[wr_base], wr_dat[wr_base]}, 32'h0001_5555);
    chk("swap_wr1", {13'b0, wr_sel[wr_base+1], wr_dat[wr_base+1]}, 32'h0006_AAAA);
    chk("swap_rel0", wr_rel[wr_base], 3);
    chk("swap_rel1", wr_rel[wr_base+1], 4);
    chk("swap_r1", {16'b0, rf[1]}, 32'h5555);
    chk("swap_r6", {16'b0, rf[6]}, 32'hAAAA);

    // LDI R7 then CLR R7, neither reads
    run_cmd(2'b10, 3'd7, 3'd3, 16'hBEEF, 2, "ldi_r7");
    chk("ldi_r7_val", {16'b0, rf[7]}, 32'hBEEF);
    chk("ldi_r7_rdn", rd_n - rd_base, 0);
    run_cmd(2'b11, 3'd7, 3'd3, 16'h1357, 2, "clr_r7");
    chk("clr_r7_val", {16'b0, rf[7]}, 32'h0000);
    chk("clr_r7_rdn", rd_n - rd_base, 0);
    chk("clr_r7_wrn", wr_n - wr_base, 1);

    // Three commands with cmd_valid held high; fields change while busy
    q_op[0] = 2'b10; q_rd[0] = 3'd0; q_rs[0] = 3'd0; q_imm[0] = 16'h1111;
    q_op[1] = 2'b00; q_rd[1] = 3'd4; q_rs[1] = 3'd0; q_imm[1] = 16'h0000;
    q_op[2] = 2'b10; q_rd[2] = 3'd3; q_rs[2] = 3'd0; q_imm[2] = 16'h0F0F;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = q_op[0]; cmd_rd = q_rd[0]; cmd_rs = q_rs[0]; cmd_imm = q_imm[0];
    n_acc = 0; viol = 0; done_cnt = 0; pending = 1'b0;
    acc_at[0] = -1; acc_at[1] = -1; acc_at[2] = -1;
    for (int c = 0; c < 14; c++) begin
      if (busy && cmd_ready) viol++;
      if (done) done_cnt++;
      if (cmd_valid && cmd_ready && n_acc < 3) begin
        acc_at[n_acc] = c;
        n_acc++;
        pending = 1'b1;
      end
      @(negedge clk);
      if (pending) begin
        pending = 1'b0;
        if (n_acc < 3) begin
          cmd_op = q_op[n_acc]; cmd_rd = q_rd[n_acc]; cmd_rs = q_rs[n_acc]; cmd_imm = q_imm[n_acc];
        end else begin
          cmd_valid = 1'b0; cmd_op = 2'b11; cmd_rd = 3'd7; cmd_rs = 3'd7; cmd_imm = 16'hDEAD;
        end
      end
    end
    chk("b2b_acc0", acc_at[0], 0);
    chk("b2b_acc1", acc_at[1], 3);
    chk("b2b_acc2", acc_at[2], 7);
    chk("b2b_viol", viol, 0);
    chk("b2b_done", done_cnt, 3);
    chk("b2b_r0", {16'b0, rf[0]}, 32'h1111);
    chk("b2b_r4", {16'b0, rf[4]}, 32'h1111);
    chk("b2b_r3", {16'b0, rf[3]}, 32'h0F0F);
    chk("b2b_r7", {16'b0, rf[7]}, 32'h0000);

    // SWAP with rs == rd
    run_cmd(2'b01, 3'd3, 3'd3, 16'h0000, 5, "swap_same");
    chk("swap_same_wrn", wr_n - wr_base, 2);
    chk("swap_same_wr0", {13'b0, wr_sel[wr_base], wr_dat[wr_base]}, 32'h0003_0F0F);
    chk("swap_same_wr1", {13'b0, wr_sel[wr_base+1], wr_dat[wr_base+1]}, 32'h0003_0F0F);
    chk("swap_same_r3", {16'b0, rf[3]}, 32'h0F0F);

    // Reset asserted during the WR_D cycle of SWAP R1 <-> R6
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rd = 3'd1; cmd_rs = 3'd6; cmd_imm = 16'h0;
    wr_base = wr_n;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_wr_d_we", {31'b0, rf_write_enable}, 32'd1);
    chk("abort_wr_d_dat", {16'b0, rf_data_out}, 32'hAAAA);
    rst = 1'b1;
    #1;
    chk("abort_we", {31'b0, rf_write_enable}, 32'd0);
    chk("abort_oe", {31'b0, rf_output_enable}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_ready", {31'b0, cmd_ready}, 32'd1);
    chk("abort_sels", {26'b0, rf_sel_out, rf_sel_in}, 32'd0);
    chk("abort_dout", {16'b0, rf_data_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_wrn", wr_n - wr_base, 0);
    chk("abort_ready_after", {31'b0, cmd_ready}, 32'd1);
    chk("abort_r1", {16'b0, rf[1]}, 32'h5555);
    chk("abort_r6", {16'b0, rf[6]}, 32'hAAAA);
    chk("no_overlap", both_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
